// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and the result-entry type for the CDB arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cdb_arbiter_pkg;

  localparam int ROB_SIZE_WIDTH  = 4;
  localparam int QUEUE_DEPTH     = 2;
  localparam int QUEUE_PTR_WIDTH = 1;

  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_MEM = 1'b1;

  // One result as carried on the bus and stored in a source FIFO.
  typedef struct packed {
    logic [31:0]               value;
    logic [ROB_SIZE_WIDTH-1:0] dependency;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO (value + ROB tag), flushable, freezes while rdy_in is low.
// Latency: head reflects a push on the cycle after the push edge.
// Backpressure: full_out reports count == DEPTH; a push while full is dropped.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = cdb_arbiter_pkg::QUEUE_DEPTH,
  parameter int PTR_W = cdb_arbiter_pkg::QUEUE_PTR_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             push_in,
  input  cdb_entry_t       push_dat,
  input  logic             pop_in,
  output cdb_entry_t       head_dat,
  output logic [PTR_W:0]   count_out,
  output logic             full_out,
  output logic             empty_out
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  cdb_entry_t       mem_q [DEPTH];
  cdb_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_out  = (count_q == DEPTH_CNT);
  assign empty_out = (count_q == '0);
  assign count_out = count_q;
  assign head_dat  = mem_q[rd_ptr_q];
  assign push_ok   = push_in && !full_out;
  assign pop_ok    = pop_in && !empty_out;

  // Next-state: flush wins, otherwise push/pop; everything holds while not ready.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rdy_in) begin
      if (flush_in) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (push_ok) begin
          mem_d[wr_ptr_q] = push_dat;
          wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
          2'b10:   count_d = count_q + (PTR_W + 1)'(1);
          2'b01:   count_d = count_q - (PTR_W + 1)'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB broadcast between ALU and memory results.
// Latency: one cycle best case (same-cycle bypass into the output register).
// Backpressure: per-source FIFO absorbs lost arbitrations; *_full_out tells the producer to stall.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int QUEUE_DEPTH     = cdb_arbiter_pkg::QUEUE_DEPTH,
  parameter int QUEUE_PTR_WIDTH = cdb_arbiter_pkg::QUEUE_PTR_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      need_flush_in,
  input  logic                      alu_valid,
  input  logic [31:0]               alu_value,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_dependency,
  output logic                      alu_full_out,
  input  logic                      mem_valid,
  input  logic [31:0]               mem_value,
  input  logic [ROB_SIZE_WIDTH-1:0] mem_dependency,
  output logic                      mem_full_out,
  output logic                      cdb_valid,
  output logic [31:0]               cdb_value,
  output logic [ROB_SIZE_WIDTH-1:0] cdb_dependency,
  output logic                      cdb_src
);

  cdb_entry_t alu_in, mem_in;
  cdb_entry_t alu_head, mem_head;
  cdb_entry_t alu_cand, mem_cand;
  logic [QUEUE_PTR_WIDTH:0] alu_count, mem_count;
  logic alu_empty, mem_empty;
  logic alu_cand_vld, mem_cand_vld;
  logic alu_grant, mem_grant;
  logic alu_push, alu_pop, mem_push, mem_pop;

  logic       cdb_valid_q, cdb_valid_d;
  cdb_entry_t cdb_entry_q, cdb_entry_d;
  logic       cdb_src_q, cdb_src_d;
  // Source that wins the next tie.
  logic       rr_q, rr_d;

  assign alu_in = '{value: alu_value, dependency: alu_dependency};
  assign mem_in = '{value: mem_value, dependency: mem_dependency};

  // Candidate selection: queued head first so per-source order holds, else bypass the live input.
  always_comb begin
    alu_cand_vld = (alu_count != '0) || alu_valid;
    mem_cand_vld = (mem_count != '0) || mem_valid;
    alu_cand     = alu_empty ? alu_in : alu_head;
    mem_cand     = mem_empty ? mem_in : mem_head;
    alu_grant    = alu_cand_vld && (!mem_cand_vld || (rr_q == CDB_SRC_ALU));
    mem_grant    = mem_cand_vld && !alu_grant;
    alu_pop      = alu_grant && !alu_empty;
    mem_pop      = mem_grant && !mem_empty;
    alu_push     = alu_valid && !(alu_grant && alu_empty);
    mem_push     = mem_valid && !(mem_grant && mem_empty);
  end

  cdb_src_fifo #(.DEPTH(QUEUE_DEPTH), .PTR_W(QUEUE_PTR_WIDTH)) u_alu_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush_in  (need_flush_in),
    .push_in   (alu_push),
    .push_dat  (alu_in),
    .pop_in    (alu_pop),
    .head_dat  (alu_head),
    .count_out (alu_count),
    .full_out  (alu_full_out),
    .empty_out (alu_empty)
  );

  cdb_src_fifo #(.DEPTH(QUEUE_DEPTH), .PTR_W(QUEUE_PTR_WIDTH)) u_mem_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush_in  (need_flush_in),
    .push_in   (mem_push),
    .push_dat  (mem_in),
    .pop_in    (mem_pop),
    .head_dat  (mem_head),
    .count_out (mem_count),
    .full_out  (mem_full_out),
    .empty_out (mem_empty)
  );

  // Output register and RR pointer next-state; payload holds when nothing is granted.
  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_entry_d = cdb_entry_q;
    cdb_src_d   = cdb_src_q;
    rr_d        = rr_q;
    if (rdy_in) begin
      if (need_flush_in) begin
        cdb_valid_d = 1'b0;
        rr_d        = CDB_SRC_ALU;
      end else begin
        cdb_valid_d = alu_grant || mem_grant;
        if (alu_grant) begin
          cdb_entry_d = alu_cand;
          cdb_src_d   = CDB_SRC_ALU;
        end else if (mem_grant) begin
          cdb_entry_d = mem_cand;
          cdb_src_d   = CDB_SRC_MEM;
        end
        if (alu_cand_vld && mem_cand_vld) begin
          rr_d = alu_grant ? CDB_SRC_MEM : CDB_SRC_ALU;
        end
      end
    end
  end

  // Broadcast registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cdb_valid_q <= 1'b0;
      cdb_entry_q <= '0;
      cdb_src_q   <= CDB_SRC_ALU;
      rr_q        <= CDB_SRC_ALU;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_entry_q <= cdb_entry_d;
      cdb_src_q   <= cdb_src_d;
      rr_q        <= rr_d;
    end
  end

  assign cdb_valid      = cdb_valid_q;
  assign cdb_value      = cdb_entry_q.value;
  assign cdb_dependency = cdb_entry_q.dependency;
  assign cdb_src        = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: inputs change and outputs are sampled on the falling edge.
// Latency: n/a.
// Backpressure: producers in the streaming step honour *_full_out.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        need_flush_in;
  logic        alu_valid;
  logic [31:0] alu_value;
  logic [3:0]  alu_dependency;
  logic        alu_full_out;
  logic        mem_valid;
  logic [31:0] mem_value;
  logic [3:0]  mem_dependency;
  logic        mem_full_out;
  logic        cdb_valid;
  logic [31:0] cdb_value;
  logic [3:0]  cdb_dependency;
  logic        cdb_src;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  cdb_arbiter dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .need_flush_in  (need_flush_in),
    .alu_valid      (alu_valid),
    .alu_value      (alu_value),
    .alu_dependency (alu_dependency),
    .alu_full_out   (alu_full_out),
    .mem_valid      (mem_valid),
    .mem_value      (mem_value),
    .mem_dependency (mem_dependency),
    .mem_full_out   (mem_full_out),
    .cdb_valid      (cdb_valid),
    .cdb_value      (cdb_value),
    .cdb_dependency (cdb_dependency),
    .cdb_src        (cdb_src)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {valid, src, dependency, value}
  function automatic logic [63:0] bus();
    return {26'd0, cdb_valid, cdb_src, cdb_dependency, cdb_value};
  endfunction

  function automatic logic [63:0] bcast(input logic src, input logic [3:0] dep, input logic [31:0] val);
    return {26'd0, 1'b1, src, dep, val};
  endfunction

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic idle();
    alu_valid     = 1'b0;
    mem_valid     = 1'b0;
    need_flush_in = 1'b0;
    rdy_in        = 1'b1;
  endtask

  task automatic drive_alu(input logic [31:0] val, input logic [3:0] dep);
    alu_valid = 1'b1; alu_value = val; alu_dependency = dep;
  endtask

  task automatic drive_mem(input logic [31:0] val, input logic [3:0] dep);
    mem_valid = 1'b1; mem_value = val; mem_dependency = dep;
  endtask

  task automatic flush_cycle();
    idle();
    need_flush_in = 1'b1;
    tick();
    need_flush_in = 1'b0;
  endtask

  initial begin
    int ai;
    int mi;
    int alu_full_seen;
    int mem_full_seen;
    logic [3:0] edep;

    rst_in = 1'b1;
    alu_value = '0; alu_dependency = '0; mem_value = '0; mem_dependency = '0;
    idle();
    #2;
    chk("reset_bus", bus(), 64'd0);
    chk("reset_full", {alu_full_out, mem_full_out}, 64'd0);
    tick();
    rst_in = 1'b0;
    tick();

    // Single ALU result: one-cycle latency, one-cycle pulse, payload held after.
    drive_alu(32'h12345678, 4'd3);
    tick();
    idle();
    chk("single_bcast", bus(), bcast(CDB_SRC_ALU, 4'd3, 32'h12345678));
    tick();
    chk("single_gap_valid", cdb_valid, 64'd0);
    chk("single_hold_value", {cdb_dependency, cdb_value}, {4'd3, 32'h12345678});

    // Tie right after reset: ALU first, MEM next.
    drive_alu(32'hA, 4'd1);
    drive_mem(32'hB, 4'd2);
    tick();
    idle();
    chk("tie_first", bus(), bcast(CDB_SRC_ALU, 4'd1, 32'hA));
    chk("tie_mem_not_full", mem_full_out, 64'd0);
    tick();
    chk("tie_second", bus(), bcast(CDB_SRC_MEM, 4'd2, 32'hB));
    tick();
    chk("tie_gap", cdb_valid, 64'd0);

    // Fill the ALU FIFO (RR currently favours MEM), then reset between edges.
    drive_alu(32'h30, 4'd1); drive_mem(32'h40, 4'd2); tick();
    chk("fill_c0", bus(), bcast(CDB_SRC_MEM, 4'd2, 32'h40));
    drive_alu(32'h31, 4'd3); drive_mem(32'h41, 4'd4); tick();
    chk("fill_c1", bus(), bcast(CDB_SRC_ALU, 4'd1, 32'h30));
    drive_alu(32'h32, 4'd5); drive_mem(32'h42, 4'd6); tick();
    idle();
    chk("fill_c2", bus(), bcast(CDB_SRC_MEM, 4'd4, 32'h41));
    chk("fill_alu_full", alu_full_out, 64'd1);
    #1 rst_in = 1'b1;
    #1;
    chk("midrst_valid", cdb_valid, 64'd0);
    chk("midrst_dep", cdb_dependency, 64'd0);
    chk("midrst_full", {alu_full_out, mem_full_out}, 64'd0);
    tick();
    rst_in = 1'b0;
    tick();
    chk("post_rst_idle", cdb_valid, 64'd0);

    // Queue two MEM entries while ALU is granted, then flush.
    drive_alu(32'h50, 4'd1); drive_mem(32'h60, 4'd2); tick();
    chk("fl_c0", bus(), bcast(CDB_SRC_ALU, 4'd1, 32'h50));
    drive_alu(32'h51, 4'd3); drive_mem(32'h61, 4'd4); tick();
    chk("fl_c1", bus(), bcast(CDB_SRC_MEM, 4'd2, 32'h60));
    drive_alu(32'h52, 4'd5); drive_mem(32'h62, 4'd6); tick();
    chk("fl_c2", bus(), bcast(CDB_SRC_ALU, 4'd3, 32'h51));
    chk("fl_mem_full", mem_full_out, 64'd1);
    drive_alu(32'h53, 4'd7); drive_mem(32'h63, 4'd8);
    need_flush_in = 1'b1;
    tick();
    idle();
    chk("fl_valid", cdb_valid, 64'd0);
    chk("fl_full", {alu_full_out, mem_full_out}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_ghost", cdb_valid, 64'd0);
    end
    drive_alu(32'h70, 4'd9); drive_mem(32'h71, 4'd10); tick();
    idle();
    chk("fl_rr_alu", bus(), bcast(CDB_SRC_ALU, 4'd9, 32'h70));
    tick();
    chk("fl_rr_mem", bus(), bcast(CDB_SRC_MEM, 4'd10, 32'h71));

    // Six results per source, producers stall on full: 12 back-to-back alternating broadcasts.
    flush_cycle();
    ai = 0; mi = 0; alu_full_seen = 0; mem_full_seen = 0;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) begin
        edep = ((c - 1) % 2 == 1) ? 4'((c - 1) / 2 + 8) : 4'((c - 1) / 2);
        chk("rr_bcast", bus(), bcast(logic'((c - 1) % 2), edep, 32'h100 + 32'(edep)));
      end
      if (alu_full_out) alu_full_seen++;
      if (mem_full_out) mem_full_seen++;
      alu_valid = (ai < 6) && !alu_full_out;
      mem_valid = (mi < 6) && !mem_full_out;
      if (alu_valid) begin
        alu_dependency = 4'(ai); alu_value = 32'h100 + 32'(ai); ai++;
      end
      if (mem_valid) begin
        mem_dependency = 4'(mi + 8); mem_value = 32'h108 + 32'(mi); mi++;
      end
      tick();
    end
    idle();
    chk("rr_drained", cdb_valid, 64'd0);
    chk("rr_all_offered", {32'(ai), 32'(mi)}, {32'd6, 32'd6});
    chk("rr_alu_full_seen", alu_full_seen > 0, 64'd1);
    chk("rr_mem_full_seen", mem_full_seen > 0, 64'd1);

    // Two entries queued, then a three-cycle freeze.
    flush_cycle();
    drive_alu(32'h80, 4'd1); drive_mem(32'h90, 4'd2); tick();
    chk("rdy_c0", bus(), bcast(CDB_SRC_ALU, 4'd1, 32'h80));
    drive_alu(32'h81, 4'd3); drive_mem(32'h91, 4'd4); tick();
    chk("rdy_c1", bus(), bcast(CDB_SRC_MEM, 4'd2, 32'h90));
    rdy_in = 1'b0;
    drive_alu(32'hDEAD, 4'd15); drive_mem(32'hBEEF, 4'd14);
    need_flush_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_frozen", bus(), bcast(CDB_SRC_MEM, 4'd2, 32'h90));
    end
    idle();
    tick();
    chk("rdy_resume_alu", bus(), bcast(CDB_SRC_ALU, 4'd3, 32'h81));
    tick();
    chk("rdy_resume_mem", bus(), bcast(CDB_SRC_MEM, 4'd4, 32'h91));
    tick();
    chk("rdy_drained", cdb_valid, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
